id_ex_ctrl_stage: RTL
=====================

# id_ex_ctrl_stage

ID/EX control pipeline stage with integrated hazard handling. It sits directly downstream of the main instruction decoder. It registers the decoder's control bundle and the destination register into the EX stage. It detects load-use hazards and inserts bubbles, flushes on taken branches resolved in EX, and sequences the halt instruction through a drain phase into a permanent halted state.

## Interface
Parameters:
- REG_ADDR_W, 5, register-index width.
- DRAIN_CYCLES, 3, cycles spent in DRAIN before halted asserts (EX, MEM, WB); legal range 1..15.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch  in  1 each  decoder control outputs for the instruction in ID.
- ALUOp  in  2  decoder ALU-op class.
- HaltSignal  in  1  instruction in ID is halt (opcode 7'b1111111).
- id_rs1, id_rs2, id_rd  in  REG_ADDR_W  register indices of the instruction in ID.
- branch_taken  in  1  branch in EX resolved taken this cycle.
- ex_ALUSrc, ex_MemtoReg, ex_RegWrite, ex_MemRead, ex_MemWrite, ex_Branch  out  1 each  registered control for EX.
- ex_ALUOp  out  2  registered ALUOp.
- ex_rd  out  REG_ADDR_W  registered destination index.
- stall  out  1  combinational; hold PC and IF/ID this cycle.
- flush  out  1  combinational; clear IF/ID this cycle.
- halted  out  1  registered; core has fully drained after halt.

## Operation
- A bubble is defined as all ex_* control = 0, ALUOp = 2'b00, ex_rd = 0.
- FSM states: RUN, DRAIN, HALTED. Reset -> RUN.
- Per-cycle priority in RUN:
  1. branch_taken=1 -> flush=1, stall=0, ID/EX loads bubble. Load-use and HaltSignal in ID are ignored, because the ID instruction is wrong-path.
  2. Load-use: ex_MemRead=1, ex_rd!=0, and (ex_rd==id_rs1 or ex_rd==id_rs2) -> stall=1, flush=0, ID/EX loads bubble. Both sources are compared unconditionally, so I/LW/SW may stall spuriously; this is accepted.
  3. HaltSignal=1 -> ID/EX loads bubble, stall=1, go to DRAIN, load drain counter with DRAIN_CYCLES-1.
  4. Otherwise ID/EX loads the decoder inputs and id_rd; stall=0, flush=0.
- Halt in ID during a load-use stall: the stall takes the cycle. Halt is accepted the next cycle, when the bubble is in EX.
- DRAIN: stall=1, flush=0, ID/EX loads bubble, branch_taken ignored (no older branch can still be in EX). The counter decrements each cycle. When counter==0 -> HALTED; halted=1 from that edge.
- HALTED: absorbing until reset. stall=1, flush=0, bubble loaded every cycle, all inputs ignored.
- Counter width: 4 bits; no wrap, since it is reloaded only on the RUN->DRAIN transition.

## Timing
- All ex_* outputs and halted are registered; they are updated on the rising edge from the ID values of the previous cycle. ID-to-EX latency is 1 cycle.
- stall and flush are combinational from the current inputs and the registered state (ex_MemRead, ex_rd, FSM state).
- While reset=1, stall=0 and flush=0 (forced).
- On the first edge with reset=1: all ex_* = 0, ex_rd = 0, halted = 0, state = RUN, counter = 0.
- Reset mid-DRAIN or in HALTED returns to RUN on that edge with halted=0.
- Halt accepted at edge T -> halted=1 after edge T+DRAIN_CYCLES. For the default of 3, halted is visible 3 cycles after the DRAIN entry edge.
- A load-use stall lasts exactly one cycle: the next cycle ex_MemRead=0 because EX holds the bubble.

## Test plan
- Reset: hold reset 2 cycles with RegWrite=1 and HaltSignal=1 driven -> all ex_*=0, halted=0, stall=0, flush=0 throughout. After release with an R-type bundle (RegWrite=1, ALUOp=2'b10, id_rd=5), the next edge gives ex_RegWrite=1, ex_ALUOp=2'b10, ex_rd=5.
- Load-use: LW with id_rd=7 registered, then ID has id_rs2=7 -> stall=1 for exactly one cycle and EX gets a bubble. The following cycle the dependent instruction is registered with its bundle. With id_rd=0 instead, there is no stall.
- Branch flush: branch_taken=1 while ID holds LW (MemRead=1) and a load-use match is present -> flush=1, stall=0, ex_MemRead=0 next cycle.
- Halt drain: HaltSignal=1 in RUN -> stall=1 from that cycle. halted rises exactly 3 edges after DRAIN entry (DRAIN_CYCLES=3). stall stays 1 and ex_* stay 0 afterwards, even with new inputs.
- Halt vs branch: HaltSignal=1 and branch_taken=1 in the same cycle -> flush=1, state stays RUN, halted never asserts.
- Reset in HALTED: assert reset one cycle -> halted=0, state RUN. A new ADDI bundle (ALUSrc=1, ALUOp=2'b11) is registered normally afterwards.

Source files
------------

// File: rtl/id_ex_ctrl_stage.sv
// ID/EX control pipeline register with load-use stall, branch flush and
// halt sequencing (RUN -> DRAIN -> HALTED).
module id_ex_ctrl_stage #(
    parameter int unsigned REG_ADDR_W   = 5,
    parameter int unsigned DRAIN_CYCLES = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ALUSrc,
    input  logic                  MemtoReg,
    input  logic                  RegWrite,
    input  logic                  MemRead,
    input  logic                  MemWrite,
    input  logic                  Branch,
    input  logic [1:0]            ALUOp,
    input  logic                  HaltSignal,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  branch_taken,
    output logic                  ex_ALUSrc,
    output logic                  ex_MemtoReg,
    output logic                  ex_RegWrite,
    output logic                  ex_MemRead,
    output logic                  ex_MemWrite,
    output logic                  ex_Branch,
    output logic [1:0]            ex_ALUOp,
    output logic [REG_ADDR_W-1:0] ex_rd,
    output logic                  stall,
    output logic                  flush,
    output logic                  halted
);

    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {
        RUN    = 2'b00,
        DRAIN  = 2'b01,
        HALTED = 2'b10
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_next;
    logic              load_bubble;
    logic              load_use;

    // Loaded value in EX feeds a source of the ID instruction; x0 never hazards.
    always_comb begin
        load_use = ex_MemRead && (ex_rd != '0) &&
                   ((ex_rd == id_rs1) || (ex_rd == id_rs2));
    end

    // Next-state, drain counter, bubble select and hazard outputs.
    always_comb begin
        state_next  = state;
        cnt_next    = cnt;
        load_bubble = 1'b1;
        stall       = 1'b0;
        flush       = 1'b0;
        case (state)
            RUN: begin
                if (branch_taken) begin
                    flush = 1'b1;
                end else if (load_use) begin
                    stall = 1'b1;
                end else if (HaltSignal) begin
                    stall      = 1'b1;
                    state_next = DRAIN;
                    cnt_next   = CNT_W'(DRAIN_CYCLES - 1);
                end else begin
                    load_bubble = 1'b0;
                end
            end
            DRAIN: begin
                stall = 1'b1;
                if (cnt == '0) begin
                    state_next = HALTED;
                end else begin
                    cnt_next = cnt - CNT_W'(1);
                end
            end
            HALTED: begin
                stall = 1'b1;
            end
            default: begin
                state_next = RUN;
            end
        endcase
        if (reset) begin
            stall = 1'b0;
            flush = 1'b0;
        end
    end

    // State register and ID/EX pipeline register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= RUN;
            cnt         <= '0;
            halted      <= 1'b0;
            ex_ALUSrc   <= 1'b0;
            ex_MemtoReg <= 1'b0;
            ex_RegWrite <= 1'b0;
            ex_MemRead  <= 1'b0;
            ex_MemWrite <= 1'b0;
            ex_Branch   <= 1'b0;
            ex_ALUOp    <= 2'b00;
            ex_rd       <= '0;
        end else begin
            state  <= state_next;
            cnt    <= cnt_next;
            halted <= (state_next == HALTED);
            if (load_bubble) begin
                ex_ALUSrc   <= 1'b0;
                ex_MemtoReg <= 1'b0;
                ex_RegWrite <= 1'b0;
                ex_MemRead  <= 1'b0;
                ex_MemWrite <= 1'b0;
                ex_Branch   <= 1'b0;
                ex_ALUOp    <= 2'b00;
                ex_rd       <= '0;
            end else begin
                ex_ALUSrc   <= ALUSrc;
                ex_MemtoReg <= MemtoReg;
                ex_RegWrite <= RegWrite;
                ex_MemRead  <= MemRead;
                ex_MemWrite <= MemWrite;
                ex_Branch   <= Branch;
                ex_ALUOp    <= ALUOp;
                ex_rd       <= id_rd;
            end
        end
    end

endmodule
